freq_meter: RTL and testbench

Measures the period and high time of a slow external square wave (e.g. a divided 1 Hz tick or a pushbutton/sensor line) against the 100 MHz system clock. It is the receiving counterpart of the frequency divider: the divider generates slow clocks, and this block recovers their timing as cycle counts. It sits beside the traffic-light controller as a self-check and calibration monitor. Outputs are cycle counts plus a valid strobe and a no-signal flag.

---
 rtl/freq_meter.sv | 153 +++++++++++++++
 tb/tb_freq_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of a slow external square
// wave in clk100M cycles, with a valid strobe and a no-signal flag.
//
// Ports:
//   clk100M   in   system clock (100 MHz)
//   clr       in   synchronous active-high reset
//   sig_in    in   asynchronous slow input
//   period    out  cycles between the last two rising edges
//   high_time out  cycles from the last completed rise to its fall
//   valid     out  one-cycle strobe when period/high_time update
//   no_sig    out  no rising edge seen for TIMEOUT cycles
//   duty_ok   out  duty within TOL (constant 0 unless built with it)
//
// Build option: define DUTY_CHECK_EN to build the duty comparator.

module freq_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 149999999,
    parameter int TOL     = 1000
) (
    input  logic             clk100M,
    input  logic             clr,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             no_sig,
    output logic             duty_ok
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        NOSIG   = 2'd2
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;

    logic rise;
    logic fall;
    logic timeout;
    logic update;
    logic to_nosig;

    // s1/s2 form the synchronizer; s3 is only the edge-detect history.
    always_comb begin
        rise     = s2 & ~s3;
        fall     = ~s2 & s3;
        timeout  = (cnt >= TO_CNT);
        update   = (state == MEASURE) && rise;
        // A rise on the timeout cycle wins over the timeout.
        to_nosig = (state != NOSIG) && !rise && timeout;
    end

    always_ff @(posedge clk100M) begin
        if (clr) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            no_sig    <= 1'b0;
            state     <= IDLE;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;

            // Counts cycles since the last rise; never wraps.
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (to_nosig) begin
                state     <= NOSIG;
                no_sig    <= 1'b1;
                period    <= '0;
                high_time <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period    <= cnt;
                            high_time <= hcnt;
                            valid     <= 1'b1;
                        end else if (fall) begin
                            hcnt <= cnt;
                        end
                    end
                    NOSIG: begin
                        // Re-arm with a fresh count; no strobe here.
                        if (rise) begin
                            no_sig <= 1'b0;
                            state  <= MEASURE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_CHECK_EN
    // Two extra bits hold 2*hcnt and the difference without overflow.
    localparam int DW = CNT_W + 2;
    localparam logic [DW-1:0] TOL2 = DW'(2 * TOL);

    logic [DW-1:0] two_h;
    logic [DW-1:0] p_ext;
    logic [DW-1:0] diff;
    logic          duty_pass;

    always_comb begin
        two_h     = {1'b0, hcnt, 1'b0};
        p_ext     = {2'b00, cnt};
        diff      = (two_h >= p_ext) ? (two_h - p_ext) : (p_ext - two_h);
        duty_pass = (diff <= TOL2);
    end

    always_ff @(posedge clk100M) begin
        if (clr) begin
            duty_ok <= 1'b0;
        end else if (to_nosig) begin
            duty_ok <= 1'b0;
        end else if (update) begin
            duty_ok <= duty_pass;
        end
    end
`else
    // No comparator in this build; TOL has no effect.
    assign duty_ok = 1'b0 & (TOL >= 0);
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed, table-driven bench for freq_meter with
// TIMEOUT=1000 and TOL=2.

module tb_freq_meter;

    localparam int CNT_W   = 28;
    localparam int TIMEOUT = 1000;
    localparam int TOL     = 2;

    logic             clk100M = 1'b0;
    logic             clr     = 1'b0;
    logic             sig_in  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             no_sig;
    logic             duty_ok;

    freq_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .TOL    (TOL)
    ) dut (
        .clk100M  (clk100M),
        .clr      (clr),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .no_sig   (no_sig),
        .duty_ok  (duty_ok)
    );

    always #5 clk100M = ~clk100M;

    int n_chk = 0;
    int n_err = 0;

    // Values sampled at the negedge, before the new input is driven.
    int o_period;
    int o_high;
    bit o_valid;
    bit o_nosig;
    bit o_duty;

    typedef struct {
        int p;
        int h;
        int n;
        int exp_period;
        int exp_high;
        bit exp_duty;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Sample outputs (state after the previous posedge), then drive.
    task automatic cyc(input logic s);
        @(negedge clk100M);
        o_period = int'(period);
        o_high   = int'(high_time);
        o_valid  = valid;
        o_nosig  = no_sig;
        o_duty   = duty_ok;
        sig_in   = s;
    endtask

    task automatic do_clr(input string nm);
        @(negedge clk100M);
        clr    = 1'b1;
        sig_in = 1'b0;
        @(negedge clk100M);
        chk({nm, " rst period"}, int'(period), 0);
        chk({nm, " rst high"}, int'(high_time), 0);
        chk({nm, " rst valid"}, int'(valid), 0);
        chk({nm, " rst no_sig"}, int'(no_sig), 0);
        chk({nm, " rst duty"}, int'(duty_ok), 0);
        clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    nv;
        bit    ns;
        bit    s;
        string nm;
        nv = 0;
        ns = 1'b0;
        nm = $sformatf("vec%0d p%0d h%0d", idx, v.p, v.h);
        do_clr(nm);
        for (int j = 0; j < v.n * v.p + 3; j++) begin
            s = (j < v.n * v.p) && ((j % v.p) < v.h);
            cyc(s);
            if (o_nosig) ns = 1'b1;
            if (o_valid) begin
                nv++;
                // Rise driven at i shows valid at sample i+3.
                chk({nm, " latency"},
                    int'((j >= 3 + v.p) && (((j - 3) % v.p) == 0)), 1);
                chk({nm, " period"}, o_period, v.exp_period);
                chk({nm, " high"}, o_high, v.exp_high);
`ifdef DUTY_CHECK_EN
                chk({nm, " duty"}, int'(o_duty), int'(v.exp_duty));
`else
                chk({nm, " duty"}, int'(o_duty), 0);
`endif
            end
        end
        chk({nm, " valid count"}, nv, v.n - 1);
        chk({nm, " no_sig seen"}, int'(ns), 0);
    endtask

    initial begin
        int nv;

        vecs[0] = '{p: 100, h: 50, n: 3, exp_period: 100,
                    exp_high: 50, exp_duty: 1'b1};
        vecs[1] = '{p: 100, h: 30, n: 3, exp_period: 100,
                    exp_high: 30, exp_duty: 1'b0};
        vecs[2] = '{p: 100, h: 51, n: 3, exp_period: 100,
                    exp_high: 51, exp_duty: 1'b1};
        vecs[3] = '{p: 100, h: 53, n: 3, exp_period: 100,
                    exp_high: 53, exp_duty: 1'b0};
        vecs[4] = '{p: 2, h: 1, n: 5, exp_period: 2,
                    exp_high: 1, exp_duty: 1'b1};
        vecs[5] = '{p: 7, h: 3, n: 4, exp_period: 7,
                    exp_high: 3, exp_duty: 1'b1};
        // Second rise lands exactly on the cnt==TIMEOUT cycle.
        vecs[6] = '{p: 1000, h: 500, n: 3, exp_period: 1000,
                    exp_high: 500, exp_duty: 1'b1};

        clr = 1'b1;
        repeat (3) @(negedge clk100M);
        clr = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Three edges then held low: timeout, clear, recovery.
        do_clr("tmo");
        for (int j = 0; j < 1210; j++) begin
            cyc((j < 300) && ((j % 100) < 50));
            if (j == 1202) begin
                chk("tmo no_sig before", int'(o_nosig), 0);
                chk("tmo period before", o_period, 100);
            end
            if (j == 1203) begin
                chk("tmo no_sig", int'(o_nosig), 1);
                chk("tmo period cleared", o_period, 0);
                chk("tmo high cleared", o_high, 0);
                chk("tmo duty cleared", int'(o_duty), 0);
            end
        end
        for (int k = 0; k < 110; k++) begin
            cyc((k % 100) < 50);
            if (k == 3) begin
                chk("tmo rearm no_sig", int'(o_nosig), 0);
                chk("tmo rearm valid", int'(o_valid), 0);
            end
            if (k == 103) begin
                chk("tmo recover valid", int'(o_valid), 1);
                chk("tmo recover period", o_period, 100);
                chk("tmo recover high", o_high, 50);
            end
        end

        // Input stuck high from reset.
        do_clr("stuck");
        nv = 0;
        for (int j = 0; j < 1100; j++) begin
            cyc(1'b1);
            if (o_valid) nv++;
            if (j == 1002) chk("stuck no_sig early", int'(o_nosig), 0);
            if (j == 1003) chk("stuck no_sig", int'(o_nosig), 1);
        end
        chk("stuck valid count", nv, 0);

        // Reset pulsed mid-period discards the partial measurement.
        do_clr("mid");
        for (int j = 0; j < 150; j++) begin
            cyc((j % 100) < 50);
            if (j == 103) chk("mid pre valid", int'(o_valid), 1);
        end
        do_clr("mid clr");
        nv = 0;
        for (int k = 0; k < 48; k++) begin
            cyc(1'b0);
            if (o_valid) nv++;
        end
        for (int k = 0; k < 110; k++) begin
            cyc((k % 100) < 50);
            if (o_valid && k < 103) nv++;
            if (k == 103) begin
                chk("mid post valid", int'(o_valid), 1);
                chk("mid post period", o_period, 100);
                chk("mid post high", o_high, 50);
            end
        end
        chk("mid first rise no valid", nv, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
